instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the clocked instruction memory. The memory has a 1-cycle read latency, is 1024 words × 32 bits, and is word-addressed internally as byte address/4.
- Owns the PC and drives the memory address.
- Tracks the memory's 1-cycle latency, kills wrong-path data on redirect, and buffers one instruction in a skid register so decode stalls lose nothing.
- Delivers instruction, PC and valid, aligned, to decode.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch byte address after reset.
- NUMBER_OF_INSTRUCTIONS, 1024, memory depth in words; fetch limit is 4*NUMBER_OF_INSTRUCTIONS bytes.
- WORD_SIZE, 32, address and instruction width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  decode cannot accept the current instruction; hold it.
- redirect  in  1  taken branch/jump from downstream; priority over stall.
- redirect_target  in  32  byte address of the new fetch path.
- mem_instruction  in  32  instruction memory read data; corresponds to the address presented one edge earlier.
- fetch_address  out  32  byte address to instruction memory; equals the PC register.
- instruction  out  32  instruction to decode; 32'h0 when not valid.
- instruction_pc  out  32  byte address of instruction; 32'h0 when not valid.
- instruction_valid  out  1  instruction/instruction_pc are meaningful.
- fetch_fault  out  1  sticky misaligned/out-of-range fetch flag.

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_VECTOR, pending=0, skid_valid=0, fault=0, state=FETCH_IDLE.
  - Outputs during reset: fetch_address=RESET_VECTOR, instruction_valid=0, instruction=0, instruction_pc=0, fetch_fault=0.
  - Reset asserted mid-operation discards skid and pending immediately.
- Registers: pc, mem_pc (address latched by memory at the last edge), pending, skid_instr, skid_pc, skid_valid, fault.
- Every edge while not faulted: mem_pc<=pc; pending<=!redirect.
- Output select:
  - skid_valid=1 → skid_instr/skid_pc.
  - else pending=1 → mem_instruction/mem_pc.
  - else invalid.
- PC update, in priority order:
  - redirect → pc<=redirect_target.
  - stall && instruction_valid → hold pc.
  - else pc<=pc+4.
- Stall capture: stall=1, instruction_valid=1, skid_valid=0, redirect=0 → skid<=(mem_instruction, mem_pc), skid_valid<=1.
- Release: skid_valid=1, stall=0 → skid_valid<=0. The following cycle presents mem[pc], with no bubble.
- Stall with instruction_valid=0: PC still advances (stall only blocks delivery).
- Redirect: skid_valid<=0, pending<=0.
  - Cycle after redirect: instruction_valid=0.
  - Target instruction valid 2 cycles after redirect asserted.
  - redirect+stall in the same cycle: redirect wins.
- Fault: redirect_target[1:0]!=0, redirect_target>=4*NUMBER_OF_INSTRUCTIONS, or pc+4 reaching the limit on a sequential advance → fault<=1.
  - Faulting address is not loaded; pc holds.
  - While faulted: pending=0, instruction_valid=0, fetch_fault=1. Cleared only by reset.
  - An already-valid skid entry is still delivered before the outputs go idle.
- FSM (state enum):
  - FETCH_IDLE (no pending) → FETCH_STREAM on the first non-redirect edge.
  - FETCH_STREAM → FETCH_HELD on stall capture; → FETCH_IDLE on redirect.
  - FETCH_HELD → FETCH_STREAM on release; → FETCH_IDLE on redirect.
  - Any state → FETCH_FAULT on fault.
- Arithmetic: pc+4 is unsigned 32-bit. The fault check prevents wrap.

Decomposition:
- fetch_pkg:
  - WORD_SIZE and NUMBER_OF_INSTRUCTIONS defaults.
  - INSTR_BYTES=4.
  - fetch_state_t enum {FETCH_IDLE, FETCH_STREAM, FETCH_HELD, FETCH_FAULT}.
  - fetch_bundle_t struct {instr, pc}.
- Sub-module fetch_skid_buffer: one-entry capture/hold/release of fetch_bundle_t with its valid bit.

Test Plan:
- Release reset, memory preloaded with word n = 32'h1000_0000+n, no stall.
  - Valid first goes high 1 cycle after the first edge, with pc 0, instr 32'h1000_0000.
  - Then pc 4, 8, 12 on consecutive cycles.
- Stall=1 for 3 cycles when instruction_pc=8.
  - instruction_pc=8 and instr 32'h1000_0002 held for all 3 cycles.
  - Cycle after release: pc 12, no gap, no duplicate.
- Redirect to 32'h40 while pc 16 is valid.
  - Next cycle invalid.
  - Then pc 32'h40, instr 32'h1000_0010.
- Redirect to 32'h80 during an active stall with skid full.
  - Skid dropped, one invalid cycle.
  - Then pc 32'h80 regardless of stall.
- Redirect to 32'h42 (misaligned), and separately to 32'h1000 (limit).
  - fetch_fault=1, instruction_valid=0, fetch_address unchanged, until reset.
  - Sequential run to pc 32'hFFC also faults after delivering 32'hFFC.
- Assert reset asynchronously mid-stall, between clock edges.
  - Outputs zero and fetch_address=RESET_VECTOR immediately.
  - Restart behaves as in the first scenario.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned WORD_SIZE                  = 32;
  localparam int unsigned DEFAULT_NUMBER_OF_INSTRUCTIONS = 1024;
  localparam int unsigned INSTR_BYTES                = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_STREAM,
    FETCH_HELD,
    FETCH_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] pc;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid register holding an instruction/PC pair while decode stalls.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          capture_i,
  input  logic          release_i,
  input  logic          flush_i,
  input  fetch_bundle_t data_i,
  output logic          valid_o,
  output fetch_bundle_t data_o
);

  logic          valid_q, valid_d;
  fetch_bundle_t data_q, data_d;

  // Flush beats capture beats release.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture_i && !valid_q) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (release_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, tracks the 1-cycle memory latency, and feeds decode
// through a one-entry skid buffer so stalls lose nothing.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR           = '0,
  parameter int unsigned          NUMBER_OF_INSTRUCTIONS = DEFAULT_NUMBER_OF_INSTRUCTIONS
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [WORD_SIZE-1:0] redirect_target_i,
  input  logic [WORD_SIZE-1:0] mem_instruction_i,
  output logic [WORD_SIZE-1:0] fetch_address_o,
  output logic [WORD_SIZE-1:0] instruction_o,
  output logic [WORD_SIZE-1:0] instruction_pc_o,
  output logic                 instruction_valid_o,
  output logic                 fetch_fault_o
);

  localparam logic [WORD_SIZE:0] FETCH_LIMIT =
      {1'b0, WORD_SIZE'(INSTR_BYTES * NUMBER_OF_INSTRUCTIONS)};

  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] mem_pc_q, mem_pc_d;
  logic                 pending_q, pending_d;
  logic                 fault_q, fault_d;
  fetch_state_t         state_q, state_d;

  logic          skid_valid;
  fetch_bundle_t skid_bundle, mem_bundle, out_bundle;
  logic          valid, hold, capture, release_skid, redirect_bad;
  logic [WORD_SIZE:0] pc_inc;

  assign mem_bundle   = '{instr: mem_instruction_i, pc: mem_pc_q};
  assign valid        = skid_valid | pending_q;
  assign out_bundle   = skid_valid ? skid_bundle : mem_bundle;
  assign hold         = stall_i & valid;
  assign capture      = stall_i & valid & ~skid_valid & ~redirect_i;
  assign release_skid = skid_valid & ~stall_i;
  // Widened by one bit so the limit compare can never be fooled by wrap.
  assign pc_inc       = {1'b0, pc_q} + (WORD_SIZE + 1)'(INSTR_BYTES);
  assign redirect_bad = (redirect_target_i[1:0] != 2'b00) ||
                        ({1'b0, redirect_target_i} >= FETCH_LIMIT);

  fetch_skid_buffer u_skid (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .capture_i (capture),
    .release_i (release_skid),
    .flush_i   (redirect_i),
    .data_i    (mem_bundle),
    .valid_o   (skid_valid),
    .data_o    (skid_bundle)
  );

  always_comb begin
    pc_d      = pc_q;
    mem_pc_d  = mem_pc_q;
    pending_d = 1'b0;
    fault_d   = fault_q;
    if (!fault_q) begin
      mem_pc_d  = pc_q;
      pending_d = ~redirect_i;
      if (redirect_i) begin
        if (redirect_bad) begin
          fault_d = 1'b1;
        end else begin
          pc_d = redirect_target_i;
        end
      end else if (!hold) begin
        if (pc_inc >= FETCH_LIMIT) begin
          fault_d = 1'b1;
        end else begin
          pc_d = pc_inc[WORD_SIZE-1:0];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (fault_d) begin
      state_d = FETCH_FAULT;
    end else if (redirect_i) begin
      state_d = FETCH_IDLE;
    end else begin
      unique case (state_q)
        FETCH_IDLE:   state_d = FETCH_STREAM;
        FETCH_STREAM: if (capture) state_d = FETCH_HELD;
        FETCH_HELD:   if (release_skid) state_d = FETCH_STREAM;
        FETCH_FAULT:  state_d = FETCH_FAULT;
        default:      state_d = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= RESET_VECTOR;
      mem_pc_q  <= '0;
      pending_q <= 1'b0;
      fault_q   <= 1'b0;
      state_q   <= FETCH_IDLE;
    end else begin
      pc_q      <= pc_d;
      mem_pc_q  <= mem_pc_d;
      pending_q <= pending_d;
      fault_q   <= fault_d;
      state_q   <= state_d;
    end
  end

  assign fetch_address_o     = pc_q;
  assign instruction_valid_o = valid;
  assign instruction_o       = valid ? out_bundle.instr : '0;
  assign instruction_pc_o    = valid ? out_bundle.pc : '0;
  assign fetch_fault_o       = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch with a 1-cycle memory model.
module tb_instruction_fetch;

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] target;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        fault;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] fetch_address, instruction, instruction_pc;
  logic        instruction_valid, fetch_fault;

  logic [31:0] mem [1024];
  vec_t        vecs [20];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[fetch_address[11:2]];

  instruction_fetch #(
    .RESET_VECTOR           (32'h0000_0000),
    .NUMBER_OF_INSTRUCTIONS (1024)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .stall_i             (stall),
    .redirect_i          (redirect),
    .redirect_target_i   (redirect_target),
    .mem_instruction_i   (mem_rdata),
    .fetch_address_o     (fetch_address),
    .instruction_o       (instruction),
    .instruction_pc_o    (instruction_pc),
    .instruction_valid_o (instruction_valid),
    .fetch_fault_o       (fetch_fault)
  );

  function automatic vec_t mk(logic s, logic r, logic [31:0] t, logic v, logic [31:0] p,
                              logic [31:0] i, logic [31:0] a, logic f);
    vec_t x;
    x.stall = s; x.redir = r; x.target = t; x.valid = v;
    x.pc = p; x.instr = i; x.addr = a; x.fault = f;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    chk({tag, " valid"}, {31'b0, instruction_valid}, {31'b0, v.valid});
    chk({tag, " pc"}, instruction_pc, v.pc);
    chk({tag, " instr"}, instruction, v.instr);
    chk({tag, " addr"}, fetch_address, v.addr);
    chk({tag, " fault"}, {31'b0, fetch_fault}, {31'b0, v.fault});
  endtask

  // Called at a falling edge: drive inputs, check, advance past one rising edge.
  task automatic step(input string tag, input vec_t v);
    stall = v.stall;
    redirect = v.redir;
    redirect_target = v.target;
    #1;
    check_outputs(tag, v);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = '0;
    @(negedge clk);
    #1;
    check_outputs(tag, mk(0, 0, 0, 0, 0, 0, 32'h0, 0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int n = 0; n < 1024; n++) mem[n] = 32'h1000_0000 + n;

    // stall, redirect, target | valid, pc, instr, fetch_address, fault
    vecs[0]  = mk(0, 0, 0,        0, 32'h00, 32'h0,         32'h00, 0);
    vecs[1]  = mk(0, 0, 0,        1, 32'h00, 32'h1000_0000, 32'h04, 0);
    vecs[2]  = mk(0, 0, 0,        1, 32'h04, 32'h1000_0001, 32'h08, 0);
    vecs[3]  = mk(1, 0, 0,        1, 32'h08, 32'h1000_0002, 32'h0C, 0);
    vecs[4]  = mk(1, 0, 0,        1, 32'h08, 32'h1000_0002, 32'h0C, 0);
    vecs[5]  = mk(1, 0, 0,        1, 32'h08, 32'h1000_0002, 32'h0C, 0);
    vecs[6]  = mk(0, 0, 0,        1, 32'h08, 32'h1000_0002, 32'h0C, 0);
    vecs[7]  = mk(0, 0, 0,        1, 32'h0C, 32'h1000_0003, 32'h10, 0);
    vecs[8]  = mk(0, 1, 32'h40,   1, 32'h10, 32'h1000_0004, 32'h14, 0);
    vecs[9]  = mk(0, 0, 0,        0, 32'h00, 32'h0,         32'h40, 0);
    vecs[10] = mk(0, 0, 0,        1, 32'h40, 32'h1000_0010, 32'h44, 0);
    vecs[11] = mk(1, 0, 0,        1, 32'h44, 32'h1000_0011, 32'h48, 0);
    vecs[12] = mk(1, 1, 32'h80,   1, 32'h44, 32'h1000_0011, 32'h48, 0);
    vecs[13] = mk(1, 0, 0,        0, 32'h00, 32'h0,         32'h80, 0);
    vecs[14] = mk(1, 0, 0,        1, 32'h80, 32'h1000_0020, 32'h84, 0);
    vecs[15] = mk(0, 0, 0,        1, 32'h80, 32'h1000_0020, 32'h84, 0);
    vecs[16] = mk(0, 1, 32'h42,   1, 32'h84, 32'h1000_0021, 32'h88, 0);
    vecs[17] = mk(0, 0, 0,        0, 32'h00, 32'h0,         32'h88, 1);
    vecs[18] = mk(0, 1, 32'h100,  0, 32'h00, 32'h0,         32'h88, 1);
    vecs[19] = mk(0, 0, 0,        0, 32'h00, 32'h0,         32'h88, 1);

    do_reset("reset0");
    for (int k = 0; k < 20; k++) step($sformatf("vec%0d", k), vecs[k]);

    // Redirect beyond the memory limit.
    do_reset("reset1");
    step("lim0", mk(0, 1, 32'h1000, 0, 0, 0, 32'h0, 0));
    step("lim1", mk(0, 0, 0,        0, 0, 0, 32'h0, 1));
    step("lim2", mk(1, 0, 0,        0, 0, 0, 32'h0, 1));

    // Sequential run into the limit: 0xFFC is still delivered.
    do_reset("reset2");
    step("seq0", mk(0, 1, 32'hFF0, 0, 0,       0,             32'h0,   0));
    step("seq1", mk(0, 0, 0,       0, 0,       0,             32'hFF0, 0));
    step("seq2", mk(0, 0, 0,       1, 32'hFF0, 32'h1000_03FC, 32'hFF4, 0));
    step("seq3", mk(0, 0, 0,       1, 32'hFF4, 32'h1000_03FD, 32'hFF8, 0));
    step("seq4", mk(0, 0, 0,       1, 32'hFF8, 32'h1000_03FE, 32'hFFC, 0));
    step("seq5", mk(0, 0, 0,       1, 32'hFFC, 32'h1000_03FF, 32'hFFC, 1));
    step("seq6", mk(0, 0, 0,       0, 0,       0,             32'hFFC, 1));
    step("seq7", mk(0, 0, 0,       0, 0,       0,             32'hFFC, 1));

    // Asynchronous reset while the skid holds pc 8, then a clean restart.
    do_reset("reset3");
    for (int k = 0; k < 5; k++) step($sformatf("arst_pre%0d", k), vecs[k]);
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_outputs("arst_now", mk(1, 0, 0, 0, 0, 0, 32'h0, 0));
    @(negedge clk);
    stall = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step($sformatf("arst_post%0d", k), vecs[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
